// File: rtl/gray_run_arbiter_if.sv
// Requester and counter-side signals of the gray run arbiter.
// master = requesters plus counter outputs; slave = the arbiter.
interface gray_run_arbiter_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 3
);
  logic             Req0;
  logic [LEN_W-1:0] Len0;
  logic             Req1;
  logic [LEN_W-1:0] Len1;
  logic [CNT_W-1:0] CntValue;
  logic             CntOverflow;
  logic             CntReset;
  logic             CntEn;
  logic [1:0]       Grant;
  logic             Busy;
  logic             Done0;
  logic             Done1;
  logic [CNT_W-1:0] Result;
  logic             Wrapped;

  modport master (
    output Req0, Len0, Req1, Len1,
    output CntValue, CntOverflow,
    input  CntReset, CntEn, Grant, Busy,
    input  Done0, Done1, Result, Wrapped
  );

  modport slave (
    input  Req0, Len0, Req1, Len1,
    input  CntValue, CntOverflow,
    output CntReset, CntEn, Grant, Busy,
    output Done0, Done1, Result, Wrapped
  );
endinterface

// File: rtl/gray_run_arbiter.sv
// Shares one gray counter between two requesters, one run of N
// enabled increments per grant, round robin on contention.
module gray_run_arbiter #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 3
) (
  input logic             Clk,
  input logic             Reset,
  gray_run_arbiter_if.slave b
);
  typedef enum logic [1:0] {
    IDLE, CLEAR, RUN, DONE
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [LEN_W-1:0] remain;
  logic             cnt_reset;
  logic             cnt_en;
  logic [1:0]       grant;
  logic             busy;
  logic             done0;
  logic             done1;
  logic [CNT_W-1:0] result;
  logic             wrapped;
  logic             pick;

  // Requester 0 wins unless only 1 asks or 0 had the last grant
  assign pick = !(b.Req0 && (!b.Req1 || last));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      remain    <= '0;
      cnt_reset <= 1'b1;
      cnt_en    <= 1'b0;
      grant     <= 2'b00;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      result    <= '0;
      wrapped   <= 1'b0;
    end else begin
      cnt_reset <= 1'b0;
      cnt_en    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (b.Req0 || b.Req1) begin
            owner     <= pick;
            last      <= pick;
            remain    <= pick ? b.Len1 : b.Len0;
            grant     <= pick ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            cnt_reset <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (remain == '0) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else begin
            cnt_en <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          remain <= remain - LEN_W'(1);
          if (remain == LEN_W'(1)) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end else begin
            cnt_en <= 1'b1;
          end
        end
        DONE: begin
          result  <= b.CntValue;
          wrapped <= b.CntOverflow;
          grant   <= 2'b00;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign b.CntReset = cnt_reset;
  assign b.CntEn    = cnt_en;
  assign b.Grant    = grant;
  assign b.Busy     = busy;
  assign b.Done0    = done0;
  assign b.Done1    = done1;
  assign b.Result   = result;
  assign b.Wrapped  = wrapped;
endmodule

// File: tb/tb_gray_run_arbiter.sv
// Bench for gray_run_arbiter: gray counter model, vector table,
// corner sequences and random traffic against a run-level model.
module tb_gray_run_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  gray_run_arbiter_if #(.LEN_W(4), .CNT_W(3)) bus ();

  gray_run_arbiter #(.LEN_W(4), .CNT_W(3)) dut (
    .Clk   (clk),
    .Reset (rst),
    .b     (bus.slave)
  );

  // Environment: the shared 3-bit gray counter with sticky overflow
  logic [2:0] cbin;
  logic       covf;
  always @(posedge clk or posedge bus.CntReset) begin
    if (bus.CntReset) begin
      cbin <= 3'd0;
      covf <= 1'b0;
    end else if (bus.CntEn) begin
      cbin <= cbin + 3'd1;
      if (cbin == 3'd7) covf <= 1'b1;
    end
  end
  assign bus.CntValue    = cbin ^ (cbin >> 1);
  assign bus.CntOverflow = covf;

  typedef struct {
    bit         r0;
    bit         r1;
    int         l0;
    int         l1;
    int         own;
    int         len;
    logic [2:0] res;
    bit         wrp;
  } vec_t;

  vec_t tbl[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gray_of(input int n);
    int m;
    m = n % 8;
    return 3'(m ^ (m >> 1));
  endfunction

  task automatic drop_req(input int own);
    if (own == 0) bus.Req0 = 1'b0;
    else bus.Req1 = 1'b0;
  endtask

  // One granted run: grant, CLEAR, len enables, Done, then Result.
  task automatic do_run(input int own, input int len,
                        input logic [2:0] res, input bit wrp,
                        input int drop_at, input bit keep,
                        input int gap);
    int n, cyc, ens;
    bit gok;
    logic [1:0] g;
    g = (own == 1) ? 2'b10 : 2'b01;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.Grant == 2'b00 && n < 50);
    if (bus.Grant == 2'b00) begin
      check("grant_timeout", 0, 1);
      return;
    end
    if (gap >= 0) check("idle_gap", n, gap);
    check("grant", bus.Grant, g);
    check("clear_rst", bus.CntReset, 1);
    check("clear_en", bus.CntEn, 0);
    check("clear_busy", bus.Busy, 1);
    cyc = 1;
    ens = 0;
    gok = 1'b1;
    while (!(bus.Done0 || bus.Done1) && cyc < 40) begin
      tick();
      cyc++;
      if (bus.Grant != g) gok = 1'b0;
      if (bus.CntEn) begin
        ens++;
        if (ens == drop_at) begin
          drop_req(own);
          if (own == 0) bus.Len0 = 4'd1;
          else bus.Len1 = 4'd1;
        end
      end
    end
    check("run_cycles", cyc, len + 2);
    check("enables", ens, len);
    check("grant_hold", gok, 1);
    check("done_bit", {bus.Done1, bus.Done0}, g);
    check("done_en", bus.CntEn, 0);
    tick();
    if (!keep) drop_req(own);
    check("idle_grant", bus.Grant, 0);
    check("idle_busy", bus.Busy, 0);
    check("done_low", {bus.Done1, bus.Done0}, 0);
    check("result", bus.Result, res);
    check("wrapped", bus.Wrapped, wrp);
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, own, len, rlast;
    logic [2:0] keep_res;

    tbl[0] = '{1, 0, 5, 0, 0, 5, 3'b111, 0};
    tbl[1] = '{0, 1, 0, 8, 1, 8, 3'b000, 1};
    tbl[2] = '{0, 1, 0, 9, 1, 9, 3'b001, 1};
    tbl[3] = '{0, 1, 0, 7, 1, 7, 3'b100, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 0, 3'b000, 0};
    tbl[5] = '{1, 0, 15, 0, 0, 15, 3'b100, 1};

    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    bus.Len0 = 4'd0;
    bus.Len1 = 4'd0;
    #1 rst = 1'b1;
    #2;
    check("rst_grant", bus.Grant, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_cntrst", bus.CntReset, 1);
    check("rst_en", bus.CntEn, 0);
    check("rst_done", {bus.Done1, bus.Done0}, 0);
    check("rst_result", bus.Result, 0);
    check("rst_wrap", bus.Wrapped, 0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      bus.Req0 = tbl[i].r0;
      bus.Req1 = tbl[i].r1;
      bus.Len0 = 4'(tbl[i].l0);
      bus.Len1 = 4'(tbl[i].l1);
      do_run(tbl[i].own, tbl[i].len, tbl[i].res, tbl[i].wrp,
             -1, 0, -1);
    end

    // Req1 dropped and Len1 changed after two enables
    bus.Req1 = 1'b1;
    bus.Len1 = 4'd6;
    do_run(1, 6, 3'b101, 0, 2, 0, -1);

    // Reset in the middle of a run
    keep_res = bus.Result;
    check("pre_rst_result", keep_res, 3'b101);
    bus.Req0 = 1'b1;
    bus.Len0 = 4'd9;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.Grant == 2'b00 && n < 50);
    for (int i = 0; i < 4; i++) tick();
    check("mid_en", bus.CntEn, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", bus.Grant, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_en", bus.CntEn, 0);
    check("mid_rst_cntrst", bus.CntReset, 1);
    check("mid_rst_result", bus.Result, 0);
    check("mid_rst_wrap", bus.Wrapped, 0);
    tick();
    tick();
    rst = 1'b0;
    do_run(0, 9, 3'b001, 1, -1, 0, -1);

    // Both held from reset: strict alternation, one IDLE cycle apart
    bus.Req0 = 1'b1;
    bus.Req1 = 1'b1;
    bus.Len0 = 4'd2;
    bus.Len1 = 4'd3;
    pulse_reset();
    do_run(0, 2, 3'b011, 0, -1, 1, -1);
    do_run(1, 3, 3'b010, 0, -1, 1, 1);
    do_run(0, 2, 3'b011, 0, -1, 1, 1);
    do_run(1, 3, 3'b010, 0, -1, 0, 1);
    bus.Req0 = 1'b0;

    // Random traffic against a run-level model
    pulse_reset();
    rlast = 1;
    for (int it = 0; it < 40; it++) begin
      if (!bus.Req0 && $urandom_range(1, 0) == 1) begin
        bus.Req0 = 1'b1;
        bus.Len0 = 4'($urandom_range(15, 0));
      end
      if (!bus.Req1 && $urandom_range(1, 0) == 1) begin
        bus.Req1 = 1'b1;
        bus.Len1 = 4'($urandom_range(15, 0));
      end
      if (!bus.Req0 && !bus.Req1) begin
        bus.Req0 = 1'b1;
        bus.Len0 = 4'($urandom_range(15, 0));
      end
      if (bus.Req0 && bus.Req1) own = 1 - rlast;
      else own = bus.Req0 ? 0 : 1;
      len = (own == 1) ? int'(bus.Len1) : int'(bus.Len0);
      do_run(own, len, gray_of(len), (len >= 8), -1, 0, -1);
      rlast = own;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
